// File: rtl/dff_bist_ctrl.sv
// dff_bist_ctrl: LFSR stimulus driver and one-cycle-delayed response checker for a D flip-flop
module dff_bist_ctrl #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int NUM_VEC = 256,
  parameter int ERR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic d,
  input  logic q,
  input  logic qbar,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [ERR_W-1:0] err_count,
  output logic first_err_vld,
  output logic [$clog2(NUM_VEC)-1:0] first_err_idx
);
  localparam int IW = $clog2(NUM_VEC);
  localparam int VW = $clog2(NUM_VEC + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [VW-1:0] vidx;
  logic [IW-1:0] idx1;
  logic [IW-1:0] idx2;
  logic vld1;
  logic vld2;
  logic exp_prev;
  logic fail;
  logic [ERR_W-1:0] err_nxt;
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign fail = vld2 && ((q != exp_prev) || (qbar == q));
  assign err_nxt = (fail && (err_count != '1)) ? err_count + 1'b1 : err_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lfsr <= SEED_EFF;
      vidx <= '0;
      idx1 <= '0;
      idx2 <= '0;
      vld1 <= 1'b0;
      vld2 <= 1'b0;
      exp_prev <= 1'b0;
      d <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      vld2 <= vld1;
      exp_prev <= d;
      idx2 <= idx1;
      err_count <= err_nxt;
      if (fail && !first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_idx <= idx2;
      end
      case (state)
        IDLE: begin
          lfsr <= SEED_EFF;
          d <= 1'b0;
          vld1 <= 1'b0;
          if (start) begin
            state <= RUN;
            busy <= 1'b1;
            pass <= 1'b0;
            err_count <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            d <= lfsr[0];
            lfsr <= lfsr_nxt;
            vld1 <= 1'b1;
            idx1 <= '0;
            vidx <= VW'(1);
          end
        end
        RUN: begin
          if (vidx == VW'(NUM_VEC)) begin
            d <= 1'b0;
            vld1 <= 1'b0;
            state <= DRAIN;
          end else begin
            d <= lfsr[0];
            lfsr <= lfsr_nxt;
            vld1 <= 1'b1;
            idx1 <= IW'(vidx);
            vidx <= vidx + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end
        default: begin
          done <= 1'b0;
          lfsr <= SEED_EFF;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dff_bist_ctrl.sv
// tb_dff_bist_ctrl: directed tests of dff_bist_ctrl against behavioural DFF models with fault injection
module tb_dff_bist_ctrl;
  localparam int N = 256;
  localparam int NS = 300;
  localparam int EW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic d, q, qbar, busy, done, pass, fvld;
  logic [EW-1:0] ec;
  logic [7:0] fidx;
  logic ds, qs, qbs, busy_s, done_s, pass_s, fvld_s;
  logic [EW-1:0] ec_s;
  logic [8:0] fidx_s;
  logic q_ff = 1'b0;
  logic qs_ff = 1'b0;
  logic flip = 1'b0;
  int mode = 0;
  logic v [NS];
  int checks = 0;
  int passed = 0;
  dff_bist_ctrl #(.SEED(16'hACE1), .NUM_VEC(N), .ERR_W(EW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .d(d), .q(q), .qbar(qbar), .busy(busy), .done(done),
    .pass(pass), .err_count(ec), .first_err_vld(fvld), .first_err_idx(fidx)
  );
  dff_bist_ctrl #(.SEED(16'hACE1), .NUM_VEC(NS), .ERR_W(EW)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .d(ds), .q(qs), .qbar(qbs), .busy(busy_s), .done(done_s),
    .pass(pass_s), .err_count(ec_s), .first_err_vld(fvld_s), .first_err_idx(fidx_s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    q_ff <= d;
    qs_ff <= ds;
  end
  assign q = (mode == 1) ? 1'b0 : (q_ff ^ flip);
  assign qbar = ~q;
  assign qs = qs_ff;
  assign qbs = qs_ff;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int ones(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(v[i]);
    return s;
  endfunction
  task automatic run(input int again, input int fk, output logic [2:0] dh, output logic b0,
                     output int dp, output int dm);
    dp = 0;
    dm = 0;
    dh = 3'b000;
    b0 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= N + 1; k++) begin
      if (k > 0) step();
      if (k == 0) b0 = busy;
      if (k < 3) dh[2-k] = d;
      if (k < N && d !== v[k]) dm++;
      if (done) dp++;
      if (k == again - 1) start = 1'b1;
      else if (k == again) start = 1'b0;
      if (fk >= 0 && k == fk + 1) flip = 1'b1;
      else if (fk >= 0 && k == fk + 2) flip = 1'b0;
    end
  endtask
  task automatic test_reset();
    checks += 7;
    if (d !== 1'b0) $display("FAIL reset_d got %b want 0", d); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else passed++;
    if (ec !== 8'd0) $display("FAIL reset_err got %0d want 0", ec); else passed++;
    if (fvld !== 1'b0) $display("FAIL reset_fvld got %b want 0", fvld); else passed++;
    if (fidx !== 8'd0) $display("FAIL reset_fidx got %0d want 0", fidx); else passed++;
  endtask
  task automatic test_clean();
    logic [2:0] dh;
    logic b0;
    int dp, dm;
    mode = 0;
    run(-1, -1, dh, b0, dp, dm);
    checks += 10;
    if (dh !== 3'b100) $display("FAIL clean_d_first3 got %b want 100", dh); else passed++;
    if (b0 !== 1'b1) $display("FAIL clean_busy_e0 got %b want 1", b0); else passed++;
    if (dm !== 0) $display("FAIL clean_d_seq got %0d mismatches want 0", dm); else passed++;
    if (dp !== 1) $display("FAIL clean_done_pulses got %0d want 1", dp); else passed++;
    if (done !== 1'b1) $display("FAIL clean_done_e257 got %b want 1", done); else passed++;
    if (busy !== 1'b0) $display("FAIL clean_busy_e257 got %b want 0", busy); else passed++;
    if (pass !== 1'b1) $display("FAIL clean_pass got %b want 1", pass); else passed++;
    if (ec !== 8'd0) $display("FAIL clean_err got %0d want 0", ec); else passed++;
    if (fvld !== 1'b0) $display("FAIL clean_fvld got %b want 0", fvld); else passed++;
    step();
    if (done !== 1'b0) $display("FAIL clean_done_e258 got %b want 0", done); else passed++;
  endtask
  task automatic test_stuck();
    logic [2:0] dh;
    logic b0;
    int dp, dm;
    mode = 1;
    run(-1, -1, dh, b0, dp, dm);
    step();
    mode = 0;
    checks += 4;
    if (int'(ec) !== ones(0, N - 1)) $display("FAIL stuck_err got %0d want %0d", ec, ones(0, N - 1)); else passed++;
    if (fidx !== 8'd0) $display("FAIL stuck_fidx got %0d want 0", fidx); else passed++;
    if (fvld !== 1'b1) $display("FAIL stuck_fvld got %b want 1", fvld); else passed++;
    if (pass !== 1'b0) $display("FAIL stuck_pass got %b want 0", pass); else passed++;
  endtask
  task automatic test_saturate();
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int k = 1; k <= NS + 1; k++) step();
    checks += 5;
    if (done_s !== 1'b1) $display("FAIL sat_done got %b want 1", done_s); else passed++;
    if (ec_s !== 8'd255) $display("FAIL sat_err got %0d want 255", ec_s); else passed++;
    if (fidx_s !== 9'd0) $display("FAIL sat_fidx got %0d want 0", fidx_s); else passed++;
    if (fvld_s !== 1'b1) $display("FAIL sat_fvld got %b want 1", fvld_s); else passed++;
    if (pass_s !== 1'b0) $display("FAIL sat_pass got %b want 0", pass_s); else passed++;
    step();
  endtask
  task automatic test_restart_ignored();
    logic [2:0] dh;
    logic b0;
    int dp, dm;
    mode = 0;
    run(5, -1, dh, b0, dp, dm);
    checks += 5;
    if (dp !== 1) $display("FAIL restart_done_pulses got %0d want 1", dp); else passed++;
    if (done !== 1'b1) $display("FAIL restart_done_e257 got %b want 1", done); else passed++;
    if (dm !== 0) $display("FAIL restart_d_seq got %0d mismatches want 0", dm); else passed++;
    if (pass !== 1'b1) $display("FAIL restart_pass got %b want 1", pass); else passed++;
    if (ec !== 8'd0) $display("FAIL restart_err got %0d want 0", ec); else passed++;
    step();
  endtask
  task automatic test_reset_midrun();
    logic [2:0] dh;
    logic b0;
    int dp, dm;
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 100; k++) step();
    checks += 2;
    if (busy !== 1'b1) $display("FAIL midrun_busy got %b want 1", busy); else passed++;
    if (int'(ec) !== ones(0, 98)) $display("FAIL midrun_err got %0d want %0d", ec, ones(0, 98)); else passed++;
    rst = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
    if (ec !== 8'd0) $display("FAIL rstmid_err got %0d want 0", ec); else passed++;
    if (d !== 1'b0) $display("FAIL rstmid_d got %b want 0", d); else passed++;
    if (fvld !== 1'b0) $display("FAIL rstmid_fvld got %b want 0", fvld); else passed++;
    @(negedge clk);
    rst = 1'b1;
    mode = 0;
    step();
    step();
    checks += 1;
    if (busy !== 1'b0) $display("FAIL rstmid_idle_busy got %b want 0", busy); else passed++;
    run(-1, -1, dh, b0, dp, dm);
    checks += 3;
    if (dh !== 3'b100) $display("FAIL rstmid_d_first3 got %b want 100", dh); else passed++;
    if (dm !== 0) $display("FAIL rstmid_d_seq got %0d mismatches want 0", dm); else passed++;
    if (pass !== 1'b1) $display("FAIL rstmid_pass got %b want 1", pass); else passed++;
    step();
  endtask
  task automatic test_single_flip();
    logic [2:0] dh;
    logic b0;
    int dp, dm;
    mode = 0;
    run(-1, 37, dh, b0, dp, dm);
    checks += 4;
    if (ec !== 8'd1) $display("FAIL flip_err got %0d want 1", ec); else passed++;
    if (fidx !== 8'd37) $display("FAIL flip_fidx got %0d want 37", fidx); else passed++;
    if (fvld !== 1'b1) $display("FAIL flip_fvld got %b want 1", fvld); else passed++;
    if (pass !== 1'b0) $display("FAIL flip_pass got %b want 0", pass); else passed++;
  endtask
  task automatic test_back_to_back();
    logic seen;
    start = 1'b1;
    step();
    checks += 4;
    if (busy !== 1'b0) $display("FAIL b2b_busy_e258 got %b want 0", busy); else passed++;
    step();
    start = 1'b0;
    if (busy !== 1'b1) $display("FAIL b2b_busy_rearm got %b want 1", busy); else passed++;
    if (d !== 1'b1) $display("FAIL b2b_d_v0 got %b want 1", d); else passed++;
    seen = 1'b0;
    for (int k = 0; k < N + 10 && !seen; k++) begin
      step();
      if (done) seen = 1'b1;
    end
    if (seen !== 1'b1 || pass !== 1'b1) $display("FAIL b2b_done_pass got done_seen=%b pass=%b want 1 1", seen, pass); else passed++;
    step();
  endtask
  initial begin
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < NS; i++) begin
      v[i] = l[0];
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    test_clean();
    test_stuck();
    test_saturate();
    test_restart_ignored();
    test_reset_midrun();
    test_single_flip();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dff_bist_ctrl.md
# dff_bist_ctrl

Self-checking stimulus/response engine for the flip-flop interface: drives `d` into a D flip-flop DUT and checks the returned `q`/`qbar` against the expected one-cycle-delayed value. It acts as the hardware counterpart of the bench driver and monitor, so the DUT can be exercised on-chip or from a minimal bench. After a `start` request it runs a fixed-length pseudo-random vector sequence. It then reports pass/fail, an error count and the index of the first failing vector.

## Interface
Clocking and reset: one clock; reset is asynchronous and active-low (ports `clk`, `rst`).

Parameters:
- `SEED`, 16'hACE1 — LFSR load value; a value of 0 is replaced by 16'h0001.
- `NUM_VEC`, 256 — number of vectors per run, ≥ 2.
- `ERR_W`, 8 — width of the error counter, which saturates.

Ports:
- `clk`  in  1 — clock; all state updates on the rising edge.
- `rst`  in  1 — asynchronous, active-low reset.
- `start`  in  1 — run request; sampled only in IDLE.
- `d`  out  1 — stimulus to the DUT `d`; registered.
- `q`  in  1 — DUT output.
- `qbar`  in  1 — DUT complement output.
- `busy`  out  1 — high in RUN and DRAIN.
- `done`  out  1 — one-cycle pulse when the run completes.
- `pass`  out  1 — high when the last run had zero errors; held until the next start.
- `err_count`  out  ERR_W — failing vectors in the last or current run; saturating.
- `first_err_vld`  out  1 — high once any error has been seen in this run.
- `first_err_idx`  out  $clog2(NUM_VEC) — index of the first failing vector.

## Operation
- LFSR: 16-bit Fibonacci, shift right, `fb = l[0]^l[2]^l[3]^l[5]` (x^16+x^14+x^13+x^11+1), `next = {fb, l[15:1]}`. Vector i is `l[0]` after i advances from SEED.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `d` = 0, LFSR = SEED.
  - `start` = 1 moves to RUN and clears `err_count`, `pass`, `first_err_vld` and `first_err_idx`.
- RUN:
  - Each cycle, `d` <= `l[0]`, the LFSR advances, `exp` <= `l[0]`, and `vidx` increments.
  - After NUM_VEC vectors have been issued, move to DRAIN.
- DRAIN: `d` <= 0; waits one cycle for the final check, then moves to DONE.
- DONE: `done` = 1 for exactly one cycle; `pass` <= (`err_count` == 0); then back to IDLE.
- Check:
  - Performed on each edge where the check-valid pipeline bit is set (the pipeline is one stage behind the drive).
  - A vector fails if `q` != `exp_prev` OR `qbar` != ~`q`. Each vector counts as at most one error.
  - On a failure, `err_count` increments and saturates at 2^ERR_W−1.
  - On the first failure, `first_err_idx` <= index of the checked vector and `first_err_vld` <= 1.
- `start` while `busy` or in DONE is ignored; requests are not queued.
- `start` held high in IDLE re-arms immediately after DONE.

## Timing
- Reset values:
  - `d`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_vld`=0, `first_err_idx`=0.
  - State IDLE, LFSR=SEED.
- Edge numbering: E0 is the edge that samples `start`=1.
  - E0: state becomes RUN, `d` = v0, `busy` = 1.
  - Ek (k < NUM_VEC): `d` = vk.
  - The DUT shows v(k) on `q` after edge E(k+1), so v(k) is checked at E(k+2).
- DRAIN entered at E(NUM_VEC); the last check happens at E(NUM_VEC+1), which also enters DONE, raises `done`, and drops `busy`.
- `done` falls and the FSM returns to IDLE at E(NUM_VEC+2). `pass` and `err_count` are valid from E(NUM_VEC+1).
- A check that coincides with saturation leaves the counter at its maximum.
- `first_err_idx` is never overwritten by later failures in the same run.
- Reset asserted mid-run:
  - All outputs go to their reset values immediately, with no `done` pulse and no partial `pass`.
  - After release the FSM is in IDLE and waits for a new `start`.

## Test plan
- Ideal DFF DUT, SEED=16'hACE1, NUM_VEC=256 -> `d` shows 1,0,0 at E0..E2; `done` pulse at E257; `pass`=1, `err_count`=0, `first_err_vld`=0.
- `q` stuck at 0 (`qbar` = ~`q`) -> `err_count` = number of 1s in v0..v255; `first_err_idx`=0 (v0=1); `pass`=0.
- `qbar` tied to `q`, NUM_VEC=300, ERR_W=8 -> `err_count` saturates at 255; `first_err_idx`=0.
- `start` pulsed again at E5 of a run -> ignored; single `done` pulse at E(NUM_VEC+1); results identical to a clean run.
- `rst` low at E100 -> `busy`/`done`/`err_count` go to 0 asynchronously; new `start` after release gives the same `d` sequence from v0 = 1.
- Single injected `q` flip on vector 37 only -> `err_count`=1, `first_err_idx`=37, `pass`=0.
